// File: rtl/video_sprite_stream_if.sv
// AXI4-Stream video bundle for video_sprite_stream: 24-bit style pixel beats with SOF on tuser and EOL on tlast.
`timescale 1ns/1ps
interface video_sprite_stream_if #(
   parameter int DATAW = 24
);
   logic [DATAW-1:0]   tdata;
   logic               tvalid;
   logic               tready;
   logic               tuser;
   logic               tlast;
   logic [DATAW/8-1:0] tstrb;
   logic [DATAW/8-1:0] tkeep;
   logic               tid;
   logic               tdest;

   modport master (
      output tdata, tvalid, tuser, tlast, tstrb, tkeep, tid, tdest,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tuser, tlast, tstrb, tkeep, tid, tdest,
      output tready
   );
endinterface

// File: rtl/video_sprite_stream.sv
// Raster generator streaming an upscaled BRAM image over a background colour as AXI4-Stream video.
// Define VIDEO_SPRITE_KEY_EN to add key_color transparency on image pixels.
`timescale 1ns/1ps
module video_sprite_stream #(
   parameter  int DATAW    = 24,
   parameter  int SCRW     = 1920,
   parameter  int SCRH     = 1080,
   parameter  int IMGW     = 256,
   parameter  int IMGH     = 256,
   parameter  int BRAM_LAT = 1,
   localparam int ADDRW    = $clog2(IMGW*IMGH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [12:0]          pos_x,
   input  logic [12:0]          pos_y,
   input  logic [1:0]           scale,
   input  logic [DATAW-1:0]     bg_color,
`ifdef VIDEO_SPRITE_KEY_EN
   input  logic [DATAW-1:0]     key_color,
`endif
   video_sprite_stream_if.master m_axis,
   output logic                 bram_en_o,
   output logic [ADDRW-1:0]     bram_addr_o,
   input  logic [DATAW-1:0]     bram_data_i
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic               w_adv;
   logic               w_latch;
   logic               w_inject;
   logic               w_lastCol;
   logic               w_lastPix;
   logic               w_inside;
   logic               w_useImage;
   logic [12:0]        r_x;
   logic [12:0]        r_y;
   logic [12:0]        r_px;
   logic [12:0]        r_py;
   logic [1:0]         r_sc;
   logic signed [13:0] w_dx;
   logic signed [13:0] w_dy;
   logic [31:0]        w_iw;
   logic [31:0]        w_ih;
   logic [12:0]        w_col;
   logic [12:0]        w_row;
   logic [ADDRW-1:0]   w_addr;
   logic [BRAM_LAT-1:0] r_pValid;
   logic [BRAM_LAT-1:0] r_pInside;
   logic [BRAM_LAT-1:0] r_pUser;
   logic [BRAM_LAT-1:0] r_pLast;
   logic               r_tvalid;
   logic               r_tuser;
   logic               r_tlast;
   logic [DATAW-1:0]   r_tdata;

   // The whole pipe, BRAM included, freezes whenever the output beat is stalled.
   assign w_adv     = ~r_tvalid | m_axis.tready;
   assign bram_en_o = w_adv & ~rst;
   assign w_inject  = (r_state == ACTIVE);
   assign w_lastCol = (r_x == 13'(SCRW-1));
   assign w_lastPix = w_lastCol && (r_y == 13'(SCRH-1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_adv && en) begin
               w_nextState = ACTIVE;
               w_latch     = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_adv && w_lastPix) begin
               if (en) w_latch     = 1'b1;
               else    w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x  <= '0;
         r_y  <= '0;
         r_px <= '0;
         r_py <= '0;
         r_sc <= '0;
      end else begin
         if (w_latch) begin
            r_px <= pos_x;
            r_py <= pos_y;
            r_sc <= scale;
         end
         if (w_adv && w_inject) begin
            if (w_lastCol) begin
               r_x <= '0;
               r_y <= w_lastPix ? 13'd0 : r_y + 13'd1;
            end else begin
               r_x <= r_x + 13'd1;
            end
         end
      end
   end

   // Offsets are signed so images placed right of or below the beam clip instead of wrapping.
   assign w_dx     = $signed({1'b0, r_x}) - $signed({1'b0, r_px});
   assign w_dy     = $signed({1'b0, r_y}) - $signed({1'b0, r_py});
   assign w_iw     = 32'(IMGW) << r_sc;
   assign w_ih     = 32'(IMGH) << r_sc;
   assign w_inside = ~w_dx[13] && (32'(w_dx[12:0]) < w_iw) &&
                     ~w_dy[13] && (32'(w_dy[12:0]) < w_ih);
   assign w_col    = w_dx[12:0] >> r_sc;
   assign w_row    = w_dy[12:0] >> r_sc;
   assign w_addr   = ADDRW'(32'(w_row) * 32'(IMGW) + 32'(w_col));
   assign bram_addr_o = (w_inject && w_inside) ? w_addr : '0;

   // Side-band flags ride a delay line matched to the BRAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pValid  <= '0;
         r_pInside <= '0;
         r_pUser   <= '0;
         r_pLast   <= '0;
      end else if (w_adv) begin
         r_pValid[0]  <= w_inject;
         r_pInside[0] <= w_inject && w_inside;
         r_pUser[0]   <= w_inject && (r_x == 13'd0) && (r_y == 13'd0);
         r_pLast[0]   <= w_inject && w_lastCol;
         for (int i = 1; i < BRAM_LAT; i++) begin
            r_pValid[i]  <= r_pValid[i-1];
            r_pInside[i] <= r_pInside[i-1];
            r_pUser[i]   <= r_pUser[i-1];
            r_pLast[i]   <= r_pLast[i-1];
         end
      end
   end

`ifdef VIDEO_SPRITE_KEY_EN
   assign w_useImage = r_pInside[BRAM_LAT-1] && (bram_data_i != key_color);
`else
   assign w_useImage = r_pInside[BRAM_LAT-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tvalid <= 1'b0;
         r_tuser  <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
      end else if (w_adv) begin
         r_tvalid <= r_pValid[BRAM_LAT-1];
         r_tuser  <= r_pUser[BRAM_LAT-1];
         r_tlast  <= r_pLast[BRAM_LAT-1];
         r_tdata  <= w_useImage ? bram_data_i : bg_color;
      end
   end

   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tuser  = r_tuser;
   assign m_axis.tlast  = r_tlast;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tstrb  = '1;
   assign m_axis.tkeep  = '1;
   assign m_axis.tid    = 1'b0;
   assign m_axis.tdest  = 1'b0;

endmodule

// File: tb/tb_video_sprite_stream.sv
// Bench for video_sprite_stream: a 16x8 screen with a 4x2 image whose BRAM words equal their address,
// one DUT at BRAM latency 1 (always ready) and one at latency 2 (random ready).
`timescale 1ns/1ps
module tb_video_sprite_stream;

   localparam int SCRW = 16;
   localparam int SCRH = 8;
   localparam int IMGW = 4;
   localparam int IMGH = 2;
   localparam logic [23:0] BG = 24'hABCDEF;
   localparam logic [23:0] SENTINEL = 24'h5A5A5A;

   typedef struct {
      logic [23:0] data;
      logic        user;
      logic        last;
      int          x;
      int          y;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstA, rstB, enA, enB;
   logic [12:0] posX, posY;
   logic [1:0]  scale;
   logic [23:0] bg;
   logic        bramEnA, bramEnB;
   logic [2:0]  bramAddrA, bramAddrB;
   logic [23:0] bramDataA, bramDataB;
   logic [2:0]  bramStageB;

   beat_t       qA[$];
   beat_t       qB[$];
   logic [23:0] cap [2][SCRH][SCRW];
   bit          holdPend [2];
   logic [23:0] holdData [2];
   logic        holdUser [2];
   logic        holdLast [2];
   int          nChecks = 0;
   int          nFails  = 0;

   video_sprite_stream_if #(.DATAW(24)) ifA();
   video_sprite_stream_if #(.DATAW(24)) ifB();

   video_sprite_stream #(
      .DATAW(24), .SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH), .BRAM_LAT(1)
   ) dutA (
      .clk(clk), .rst(rstA), .en(enA), .pos_x(posX), .pos_y(posY), .scale(scale),
      .bg_color(bg),
`ifdef VIDEO_SPRITE_KEY_EN
      .key_color(24'hFFFFFF),
`endif
      .m_axis(ifA), .bram_en_o(bramEnA), .bram_addr_o(bramAddrA), .bram_data_i(bramDataA)
   );

   video_sprite_stream #(
      .DATAW(24), .SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH), .BRAM_LAT(2)
   ) dutB (
      .clk(clk), .rst(rstB), .en(enB), .pos_x(posX), .pos_y(posY), .scale(scale),
      .bg_color(bg),
`ifdef VIDEO_SPRITE_KEY_EN
      .key_color(24'hFFFFFF),
`endif
      .m_axis(ifB), .bram_en_o(bramEnB), .bram_addr_o(bramAddrB), .bram_data_i(bramDataB)
   );

   always #5 clk = ~clk;

   // BRAM models: each word equals its address, output holds while the enable is low.
   always @(posedge clk) begin
      if (bramEnA) bramDataA <= {21'd0, bramAddrA};
      if (bramEnB) begin
         bramStageB <= bramAddrB;
         bramDataB  <= {21'd0, bramStageB};
      end
   end

   initial begin
      ifB.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ifB.tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [23:0] modelPixel(input int px, input int py, input int sc,
                                              input int x, input int y);
      int dx;
      int dy;
      dx = x - px;
      dy = y - py;
      if (dx >= 0 && dx < (IMGW << sc) && dy >= 0 && dy < (IMGH << sc))
         return 24'((dy >> sc) * IMGW + (dx >> sc));
      return BG;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pushFrame(input int d, input int px, input int py, input int sc);
      beat_t e;
      for (int y = 0; y < SCRH; y++) begin
         for (int x = 0; x < SCRW; x++) begin
            e.data = modelPixel(px, py, sc, x, y);
            e.user = (x == 0 && y == 0);
            e.last = (x == SCRW - 1);
            e.x = x;
            e.y = y;
            if (d == 1) qB.push_back(e);
            else        qA.push_back(e);
         end
      end
   endtask

   task automatic clearCap(input int d);
      for (int y = 0; y < SCRH; y++)
         for (int x = 0; x < SCRW; x++)
            cap[d][y][x] = SENTINEL;
   endtask

   // Scoreboard for one DUT: hold stability under stall, then in-order beat comparison.
   task automatic scoreBeat(input int d, input logic v, input logic r, input logic u,
                            input logic l, input logic [23:0] td);
      beat_t e;
      string tag;
      tag = (d == 1) ? "B" : "A";
      if (holdPend[d]) begin
         checkOutput({tag, "_hold_valid"}, 32'(v), 32'd1);
         checkOutput({tag, "_hold_data"}, 32'(td), 32'(holdData[d]));
         checkOutput({tag, "_hold_flags"}, {30'd0, u, l}, {30'd0, holdUser[d], holdLast[d]});
      end
      if (v) begin
         if (((d == 1) ? qB.size() : qA.size()) == 0) begin
            checkOutput({tag, "_unexpected_beat"}, 32'(v), 32'd0);
         end else if (r) begin
            e = (d == 1) ? qB.pop_front() : qA.pop_front();
            checkOutput($sformatf("%s_data(%0d,%0d)", tag, e.x, e.y), 32'(td), 32'(e.data));
            checkOutput($sformatf("%s_tuser(%0d,%0d)", tag, e.x, e.y), 32'(u), 32'(e.user));
            checkOutput($sformatf("%s_tlast(%0d,%0d)", tag, e.x, e.y), 32'(l), 32'(e.last));
            cap[d][e.y][e.x] = td;
         end
      end
      holdPend[d] = v & ~r;
      holdData[d] = td;
      holdUser[d] = u;
      holdLast[d] = l;
   endtask

   always @(negedge clk) begin
      if (rstA) holdPend[0] = 1'b0;
      else scoreBeat(0, ifA.tvalid, ifA.tready, ifA.tuser, ifA.tlast, ifA.tdata);
   end

   always @(negedge clk) begin
      if (rstB) holdPend[1] = 1'b0;
      else scoreBeat(1, ifB.tvalid, ifB.tready, ifB.tuser, ifB.tlast, ifB.tdata);
   end

   task automatic applyStimulus(input int d, input int px, input int py, input int sc);
      @(negedge clk);
      #1;
      posX  = 13'(px);
      posY  = 13'(py);
      scale = 2'(sc);
      clearCap(d);
      pushFrame(d, px, py, sc);
      if (d == 1) enB = 1'b1;
      else        enA = 1'b1;
      @(negedge clk);
      #1;
      if (d == 1) enB = 1'b0;
      else        enA = 1'b0;
   endtask

   task automatic waitDrain(input int d, input int budget);
      int n;
      n = 0;
      while (((d == 1) ? qB.size() : qA.size()) != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput((d == 1) ? "B_drain_left" : "A_drain_left",
                  32'((d == 1) ? qB.size() : qA.size()), 32'd0);
      if (d == 1) qB.delete();
      else        qA.delete();
   endtask

   initial begin
      int nonBg;
      int n;
      rstA = 1'b1;
      rstB = 1'b1;
      enA = 1'b0;
      enB = 1'b0;
      posX = '0;
      posY = '0;
      scale = '0;
      bg = BG;
      ifA.tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_A_tvalid", 32'(ifA.tvalid), 32'd0);
      checkOutput("rst_A_tuser", 32'(ifA.tuser), 32'd0);
      checkOutput("rst_A_tlast", 32'(ifA.tlast), 32'd0);
      checkOutput("rst_A_tdata", 32'(ifA.tdata), 32'd0);
      checkOutput("rst_A_bram_en", 32'(bramEnA), 32'd0);
      checkOutput("rst_A_bram_addr", 32'(bramAddrA), 32'd0);
      checkOutput("rst_A_tstrb_tkeep", {26'd0, ifA.tstrb, ifA.tkeep}, 32'h3F);
      checkOutput("rst_A_tid_tdest", {30'd0, ifA.tid, ifA.tdest}, 32'd0);
      checkOutput("rst_B_tvalid", 32'(ifB.tvalid), 32'd0);
      checkOutput("rst_B_bram_en", 32'(bramEnB), 32'd0);
      rstA = 1'b0;
      rstB = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] T1 image at (2,3), scale 1x");
      applyStimulus(0, 2, 3, 0);
      waitDrain(0, 500);
      checkOutput("T1_pix(2,3)", 32'(cap[0][3][2]), 32'd0);
      checkOutput("T1_pix(5,3)", 32'(cap[0][3][5]), 32'd3);
      checkOutput("T1_pix(2,4)", 32'(cap[0][4][2]), 32'd4);
      checkOutput("T1_pix(5,4)", 32'(cap[0][4][5]), 32'd7);
      checkOutput("T1_pix(6,3)", 32'(cap[0][3][6]), 32'hABCDEF);
      checkOutput("T1_pix(2,2)", 32'(cap[0][2][2]), 32'hABCDEF);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("T1_idle_tvalid", 32'(ifA.tvalid), 32'd0);

      $display("[TB] T2 image at (0,0), scale 2x");
      applyStimulus(0, 0, 0, 1);
      waitDrain(0, 500);
      checkOutput("T2_pix(7,3)", 32'(cap[0][3][7]), 32'd7);
      checkOutput("T2_pix(8,0)", 32'(cap[0][0][8]), 32'hABCDEF);
      checkOutput("T2_pix(1,1)", 32'(cap[0][1][1]), 32'd0);
      checkOutput("T2_pix(2,0)", 32'(cap[0][0][2]), 32'd1);
      checkOutput("T2_pix(0,4)", 32'(cap[0][4][0]), 32'hABCDEF);

      $display("[TB] T4 clipped and off-screen placements");
      applyStimulus(0, 14, 7, 0);
      waitDrain(0, 500);
      checkOutput("T4_pix(14,7)", 32'(cap[0][7][14]), 32'd0);
      checkOutput("T4_pix(15,7)", 32'(cap[0][7][15]), 32'd1);
      checkOutput("T4_pix(13,7)", 32'(cap[0][7][13]), 32'hABCDEF);
      checkOutput("T4_pix(14,6)", 32'(cap[0][6][14]), 32'hABCDEF);
      applyStimulus(0, 20, 0, 0);
      waitDrain(0, 500);
      nonBg = 0;
      for (int y = 0; y < SCRH; y++)
         for (int x = 0; x < SCRW; x++)
            if (cap[0][y][x] !== BG) nonBg++;
      checkOutput("T4_offscreen_nonbg", 32'(nonBg), 32'd0);

      $display("[TB] T3 latency 2 with random ready");
      applyStimulus(1, 2, 3, 0);
      waitDrain(1, 3000);
      checkOutput("T3_pix(2,3)", 32'(cap[1][3][2]), 32'd0);
      checkOutput("T3_pix(5,4)", 32'(cap[1][4][5]), 32'd7);
      checkOutput("T3_pix(0,0)", 32'(cap[1][0][0]), 32'hABCDEF);

      $display("[TB] T5 back-to-back frames with mid-frame changes");
      @(negedge clk);
      #1;
      posX = 13'd2;
      posY = 13'd3;
      scale = 2'd0;
      clearCap(0);
      pushFrame(0, 2, 3, 0);
      pushFrame(0, 5, 1, 0);
      enA = 1'b1;
      repeat (64) begin
         @(negedge clk);
         #1;
      end
      posX = 13'd5;
      posY = 13'd1;
      repeat (128) begin
         @(negedge clk);
         #1;
      end
      enA = 1'b0;
      waitDrain(0, 600);
      checkOutput("T5_pix(5,1)", 32'(cap[0][1][5]), 32'd0);
      checkOutput("T5_pix(8,2)", 32'(cap[0][2][8]), 32'd7);
      checkOutput("T5_pix(2,3)", 32'(cap[0][3][2]), 32'hABCDEF);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("T5_idle_tvalid", 32'(ifA.tvalid), 32'd0);

      $display("[TB] T6 reset in the middle of a frame");
      posX = 13'd0;
      posY = 13'd0;
      scale = 2'd0;
      clearCap(0);
      pushFrame(0, 0, 0, 0);
      enA = 1'b1;
      n = 0;
      while (qA.size() > 78 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("T6_reach_beat50", 32'(qA.size() <= 78), 32'd1);
      rstA = 1'b1;
      qA.delete();
      clearCap(0);
      pushFrame(0, 0, 0, 0);
      @(negedge clk);
      #1;
      checkOutput("T6_rst_tvalid", 32'(ifA.tvalid), 32'd0);
      rstA = 1'b0;
      @(negedge clk);
      #1;
      enA = 1'b0;
      waitDrain(0, 500);
      checkOutput("T6_pix(0,0)", 32'(cap[0][0][0]), 32'd0);
      checkOutput("T6_pix(3,1)", 32'(cap[0][1][3]), 32'd7);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
